// File: rtl/rwt_sample_pkg.sv
// Shared constants for the sample packer/unpacker pair: sub-lane enable codes
// and packer state encoding.
package rwt_sample_pkg;

  localparam logic [3:0] EN_FULL = 4'b1111;
  localparam logic [3:0] EN_LOW  = 4'b0011;
  localparam logic [3:0] EN_NONE = 4'b0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HELD  = 2'd1,
    ST_FLUSH = 2'd2
  } pack_state_e;

  function automatic logic [1:0] lane_count(input logic [1:0] enables);
    return {1'b0, enables[0]} + {1'b0, enables[1]};
  endfunction

endpackage

// File: rtl/rwt_sample_pack_if.sv
// AXI-Stream style beat bundle used on both sides of the sample packer;
// EWIDTH is 2 on the lane-enable input and 4 on the sub-lane-enable output.
interface rwt_sample_pack_if #(
  parameter int EWIDTH = 2,
  parameter int UWIDTH = 1
);
  logic              ready;
  logic              valid;
  logic [63:0]       data;
  logic [EWIDTH-1:0] enables;
  logic [UWIDTH-1:0] user;
  logic              last;

  modport master (input ready, output valid, data, enables, user, last);
  modport slave  (output ready, input valid, data, enables, user, last);
endinterface

// File: rtl/rwt_sample_pack.sv
// Compacts enabled 32-bit lane samples into dense 64-bit words in stream order,
// flushing a trailing odd sample on last as a half-filled word.
module rwt_sample_pack
  import rwt_sample_pkg::*;
#(
  parameter int UWIDTH = 1
) (
  input  logic               clk,
  input  logic               aresetn,
  rwt_sample_pack_if.slave   s_axi,
  rwt_sample_pack_if.master  m_axi
);

  pack_state_e       state_q, state_d;
  logic [31:0]       hold_data_q, hold_data_d;
  logic [UWIDTH-1:0] hold_user_q, hold_user_d;

  logic              out_valid;
  logic [63:0]       out_data;
  logic [3:0]        out_en;
  logic [UWIDTH-1:0] out_user;
  logic              out_last;

  logic              load;
  logic [63:0]       load_data;
  logic [3:0]        load_en;
  logic [UWIDTH-1:0] load_user;
  logic              load_last;

  logic              slot_free;
  logic              s_ready;
  logic              accept;
  logic [1:0]        k;
  logic [31:0]       lone;

  assign slot_free = ~out_valid | m_axi.ready;
  assign s_ready   = aresetn & slot_free & (state_q != ST_FLUSH);
  assign accept    = s_axi.valid & s_ready;
  assign k         = lane_count(s_axi.enables);
  // With a single enabled lane, pick whichever lane carries it.
  assign lone      = s_axi.enables[0] ? s_axi.data[31:0] : s_axi.data[63:32];

  assign s_axi.ready   = s_ready;
  assign m_axi.valid   = out_valid;
  assign m_axi.data    = out_data;
  assign m_axi.enables = out_en;
  assign m_axi.user    = out_user;
  assign m_axi.last    = out_last;

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_user_d = hold_user_q;
    load        = 1'b0;
    load_data   = '0;
    load_en     = EN_NONE;
    load_user   = '0;
    load_last   = 1'b0;

    case (state_q)
      ST_FLUSH: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = {32'd0, hold_data_q};
          load_en   = EN_LOW;
          load_user = hold_user_q;
          load_last = 1'b1;
          state_d   = ST_EMPTY;
        end
      end

      ST_HELD: begin
        if (accept) begin
          case (k)
            2'd0: begin
              if (s_axi.last) begin
                load      = 1'b1;
                load_data = {32'd0, hold_data_q};
                load_en   = EN_LOW;
                load_user = hold_user_q;
                load_last = 1'b1;
                state_d   = ST_EMPTY;
              end
            end
            2'd1: begin
              load      = 1'b1;
              load_data = {lone, hold_data_q};
              load_en   = EN_FULL;
              load_user = hold_user_q;
              load_last = s_axi.last;
              state_d   = ST_EMPTY;
            end
            default: begin
              // Upper lane becomes the new held sample; on last it is owed as a partial word.
              load        = 1'b1;
              load_data   = {s_axi.data[31:0], hold_data_q};
              load_en     = EN_FULL;
              load_user   = hold_user_q;
              load_last   = 1'b0;
              hold_data_d = s_axi.data[63:32];
              hold_user_d = s_axi.user;
              state_d     = s_axi.last ? ST_FLUSH : ST_HELD;
            end
          endcase
        end
      end

      default: begin
        if (accept) begin
          case (k)
            2'd0: begin
              if (s_axi.last) begin
                load      = 1'b1;
                load_data = '0;
                load_en   = EN_NONE;
                load_user = s_axi.user;
                load_last = 1'b1;
              end
            end
            2'd1: begin
              if (s_axi.last) begin
                load      = 1'b1;
                load_data = {32'd0, lone};
                load_en   = EN_LOW;
                load_user = s_axi.user;
                load_last = 1'b1;
              end else begin
                hold_data_d = lone;
                hold_user_d = s_axi.user;
                state_d     = ST_HELD;
              end
            end
            default: begin
              load      = 1'b1;
              load_data = s_axi.data;
              load_en   = EN_FULL;
              load_user = s_axi.user;
              load_last = s_axi.last;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q     <= ST_EMPTY;
      hold_data_q <= '0;
      hold_user_q <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_en      <= '0;
      out_user    <= '0;
      out_last    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_user_q <= hold_user_d;
      // A new word is only produced when the slot is free, so load never overwrites a stalled word.
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_en    <= load_en;
        out_user  <= load_user;
        out_last  <= load_last;
      end else if (m_axi.ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rwt_sample_pack.sv
// Self-checking bench for rwt_sample_pack: directed packets plus a randomized
// run scored against a queue-based model of compacted sample order.
module tb_rwt_sample_pack;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  en;
    logic [2:0]  user;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  logic aresetn = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] pendData[$];
  logic [2:0]  pendUser[$];
  word_t       expQ[$];

  logic  readyRandom = 1'b0;
  logic  prevHold = 1'b0;
  word_t prevWord = '0;
  int    outCount = 0;

  rwt_sample_pack_if #(.EWIDTH(2), .UWIDTH(3)) s_if ();
  rwt_sample_pack_if #(.EWIDTH(4), .UWIDTH(3)) m_if ();

  rwt_sample_pack #(.UWIDTH(3)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .s_axi   (s_if),
    .m_axi   (m_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: samples queue up in stream order and pair off two at a time.
  task automatic model_accept(input logic [1:0] en, input logic [63:0] d,
                              input logic [2:0] u, input logic last);
    word_t produced[$];
    word_t w;
    if (en[0]) begin pendData.push_back(d[31:0]);  pendUser.push_back(u); end
    if (en[1]) begin pendData.push_back(d[63:32]); pendUser.push_back(u); end
    while (pendData.size() >= 2) begin
      w.data = {pendData[1], pendData[0]};
      w.en   = 4'b1111;
      w.user = pendUser[0];
      w.last = 1'b0;
      produced.push_back(w);
      void'(pendData.pop_front()); void'(pendData.pop_front());
      void'(pendUser.pop_front()); void'(pendUser.pop_front());
    end
    if (last) begin
      if (pendData.size() == 1) begin
        w.data = {32'd0, pendData[0]};
        w.en   = 4'b0011;
        w.user = pendUser[0];
        w.last = 1'b0;
        produced.push_back(w);
        void'(pendData.pop_front());
        void'(pendUser.pop_front());
      end else if (produced.size() == 0) begin
        w.data = 64'd0;
        w.en   = 4'b0000;
        w.user = u;
        w.last = 1'b0;
        produced.push_back(w);
      end
      produced[produced.size()-1].last = 1'b1;
    end
    foreach (produced[i]) expQ.push_back(produced[i]);
  endtask

  task automatic check_out();
    word_t cur;
    word_t exp;
    cur = {m_if.data, m_if.enables, m_if.user, m_if.last};
    if (prevHold) chk("stable_under_stall", {8'd0, cur}, {8'd0, prevWord});
    if (m_if.valid && m_if.ready) begin
      outCount++;
      if (expQ.size() == 0) begin
        chk("unexpected_output", {8'd0, cur}, 80'd0);
      end else begin
        exp = expQ.pop_front();
        chk("out_word", {8'd0, cur}, {8'd0, exp});
      end
    end
    prevHold = m_if.valid && !m_if.ready;
    prevWord = cur;
  endtask

  task automatic step(input logic v, input logic [1:0] en, input logic [63:0] data,
                      input logic [2:0] user, input logic last, output logic acc);
    @(negedge clk);
    s_if.valid   = v;
    s_if.enables = en;
    s_if.data    = data;
    s_if.user    = user;
    s_if.last    = last;
    m_if.ready   = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    check_out();
    acc = v && s_if.ready;
    if (acc) model_accept(en, data, user, last);
  endtask

  task automatic applyStimulus(input logic [1:0] en, input logic [63:0] data,
                               input logic [2:0] user, input logic last, output int tries);
    logic acc;
    tries = 0;
    acc = 1'b0;
    while (!acc) begin
      step(1'b1, en, data, user, last, acc);
      tries++;
      if (!acc && tries >= 200) begin
        chk("accept_timeout", 80'd0, 80'd1);
        break;
      end
    end
  endtask

  task automatic idle();
    logic acc;
    step(1'b0, 2'b00, 64'd0, 3'd0, 1'b0, acc);
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() != 0 && n < 300) begin
      idle();
      n++;
    end
    idle();
    chk("drain_empty", 80'(expQ.size()), 80'd0);
  endtask

  initial begin
    int tries;
    int outsBefore;
    logic [1:0] en;
    logic [63:0] d;
    logic accDummy;

    s_if.valid = 1'b0; s_if.enables = '0; s_if.data = '0; s_if.user = '0; s_if.last = 1'b0;
    m_if.ready = 1'b1;

    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {11'd0, m_if.valid, m_if.data, m_if.enables, m_if.user, m_if.last, s_if.ready},
        80'd0);
    @(negedge clk);
    aresetn = 1'b1;

    // Full beats pass straight through, one per cycle.
    applyStimulus(2'b11, 64'hA1A1A1A1_A0A0A0A0, 3'd1, 1'b0, tries);
    chk("full_beat1_tries", 80'(tries), 80'd1);
    applyStimulus(2'b11, 64'hB1B1B1B1_B0B0B0B0, 3'd2, 1'b1, tries);
    chk("full_beat2_tries", 80'(tries), 80'd1);
    drain();

    // Alternating single lanes pair up: 4 inputs, 2 outputs.
    outsBefore = outCount;
    applyStimulus(2'b01, 64'h0_0000000A, 3'd3, 1'b0, tries);
    applyStimulus(2'b10, 64'h0000000B_00000000, 3'd4, 1'b0, tries);
    applyStimulus(2'b01, 64'h0_0000000C, 3'd5, 1'b0, tries);
    applyStimulus(2'b10, 64'h0000000D_00000000, 3'd6, 1'b0, tries);
    drain();
    chk("pair_out_count", 80'(outCount - outsBefore), 80'd2);

    // Held sample plus a full last beat owes a partial word and one stall.
    applyStimulus(2'b01, 64'h0_0000AAAA, 3'd1, 1'b0, tries);
    applyStimulus(2'b11, 64'h0000B1B1_0000B0B0, 3'd2, 1'b1, tries);
    chk("flush_accept_tries", 80'(tries), 80'd1);
    idle();
    chk("flush_stall_ready", 80'(s_if.ready), 80'd0);
    idle();
    chk("after_flush_ready", 80'(s_if.ready), 80'd1);
    drain();

    // Empty last beat produces a terminator.
    applyStimulus(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 3'd7, 1'b1, tries);
    drain();

    // Random enables, lasts, gaps and output back-pressure.
    readyRandom = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 4) == 0) idle();
      en = 2'($urandom_range(0, 3));
      d  = {32'($urandom), 32'($urandom)};
      applyStimulus(en, d, 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), tries);
    end
    applyStimulus(2'b00, 64'd0, 3'd0, 1'b1, tries);
    drain();
    readyRandom = 1'b0;

    // Reset while holding a sample discards it.
    applyStimulus(2'b01, 64'h0_DEADBEEF, 3'd5, 1'b0, tries);
    @(negedge clk);
    aresetn = 1'b0;
    s_if.valid = 1'b0;
    @(negedge clk);
    #1;
    chk("midreset_outputs", {11'd0, m_if.valid, m_if.data, m_if.enables, m_if.user, m_if.last, s_if.ready},
        80'd0);
    aresetn = 1'b1;
    pendData.delete();
    pendUser.delete();
    expQ.delete();
    prevHold = 1'b0;
    applyStimulus(2'b01, 64'h0_11111111, 3'd1, 1'b0, tries);
    applyStimulus(2'b01, 64'h0_22222222, 3'd2, 1'b1, tries);
    step(1'b0, 2'b00, 64'd0, 3'd0, 1'b0, accDummy);
    chk("post_reset_no_stale", 80'(m_if.data), 80'h22222222_11111111);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
